// File: rtl/animation_pkg.sv
// Shared types and default timing constants for the game-start ladder animation.
package animation_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} anim_state_t;

    localparam int unsigned ANIM_FRAMES_PER_STEP = 8;
    localparam int unsigned ANIM_END_COUNT       = 15;
    localparam int unsigned ANIM_START_DELAY     = 30;

endpackage

// File: rtl/edge_detect.sv
// Single-bit rising-edge detector; the pulse is combinational from the live input
// and a registered copy, so it appears in the same cycle as the edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/animation_ctl.sv
// Game-start ladder animation sequencer: paces the renderer's step counter off
// vertical-blank ticks and signals completion with a one-cycle anim_done pulse.
module animation_ctl
    import animation_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = ANIM_FRAMES_PER_STEP,
    parameter int unsigned END_COUNT       = ANIM_END_COUNT,
    parameter int unsigned START_DELAY     = ANIM_START_DELAY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_game,
    input  logic       skip,
    input  logic       vblnk,
    output logic       animation,
    output logic [3:0] counter,
    output logic       anim_done
);

    localparam logic [7:0] FPS_C   = 8'(FRAMES_PER_STEP);
    localparam logic [7:0] DELAY_C = 8'(START_DELAY);
    localparam logic [3:0] END_C   = 4'(END_COUNT);

    logic tick, trig;

    edge_detect u_vblnk_edge (.clk(clk), .rst(rst), .d(vblnk),      .rise(tick));
    edge_detect u_start_edge (.clk(clk), .rst(rst), .d(start_game), .rise(trig));

    anim_state_t state, state_d;
    logic [7:0]  frame_cnt, frame_cnt_d, frame_inc;
    logic [3:0]  counter_d, counter_inc;
    logic        animation_d, anim_done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            counter   <= '0;
            animation <= 1'b0;
            anim_done <= 1'b0;
        end else begin
            state     <= state_d;
            frame_cnt <= frame_cnt_d;
            counter   <= counter_d;
            animation <= animation_d;
            anim_done <= anim_done_d;
        end
    end

    always_comb begin
        state_d     = state;
        frame_cnt_d = frame_cnt;
        counter_d   = counter;
        frame_inc   = frame_cnt + 8'd1;
        counter_inc = counter + 4'd1;

        unique case (state)
            IDLE: begin
                counter_d = '0;
                if (trig) begin
                    state_d     = (DELAY_C == 8'd0) ? RUN : DELAY;
                    frame_cnt_d = '0;
                end
            end
            DELAY: begin
                if (!start_game) begin
                    state_d     = IDLE;
                    counter_d   = '0;
                    frame_cnt_d = '0;
                end else if (skip) begin
                    state_d     = DONE;
                    counter_d   = END_C;
                    frame_cnt_d = '0;
                end else if (tick) begin
                    if (frame_inc == DELAY_C) begin
                        state_d     = RUN;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            RUN: begin
                if (!start_game) begin
                    state_d     = IDLE;
                    counter_d   = '0;
                    frame_cnt_d = '0;
                end else if (skip) begin
                    state_d     = DONE;
                    counter_d   = END_C;
                    frame_cnt_d = '0;
                end else if (tick) begin
                    if (frame_inc == FPS_C) begin
                        frame_cnt_d = '0;
                        counter_d   = counter_inc;
                        if (counter_inc == END_C) state_d = DONE;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            DONE: begin
                counter_d = END_C;
                if (!start_game) begin
                    state_d     = IDLE;
                    counter_d   = '0;
                    frame_cnt_d = '0;
                end
            end
        endcase

        // Outputs are registered from the next state so they line up with the state change.
        animation_d = (state_d == DELAY) || (state_d == RUN);
        anim_done_d = (state_d == DONE) && (state != DONE);
    end

endmodule

// File: tb/tb_animation_ctl.sv
// Scoreboard bench for animation_ctl: two instances (default and minimal parameters)
// share one stimulus stream and are checked against a tick-counting reference model.
module tb_animation_ctl;

    typedef struct packed {
        logic       anim;
        logic [3:0] cnt;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_game = 1'b0;
    logic       skip = 1'b0;
    logic       vblnk = 1'b0;
    logic       anim_a, done_a, anim_b, done_b;
    logic [3:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    animation_ctl #(.FRAMES_PER_STEP(8), .END_COUNT(15), .START_DELAY(30)) dut_a (
        .clk(clk), .rst(rst), .start_game(start_game), .skip(skip), .vblnk(vblnk),
        .animation(anim_a), .counter(cnt_a), .anim_done(done_a)
    );

    animation_ctl #(.FRAMES_PER_STEP(1), .END_COUNT(1), .START_DELAY(0)) dut_b (
        .clk(clk), .rst(rst), .start_game(start_game), .skip(skip), .vblnk(vblnk),
        .animation(anim_b), .counter(cnt_b), .anim_done(done_b)
    );

    int unsigned sd  [2] = '{30, 0};
    int unsigned fps [2] = '{8, 1};
    int unsigned ec  [2] = '{15, 1};

    // Reference: an animation is "active" for a fixed number of frame ticks after its
    // trigger; the step number is derived arithmetically from the ticks seen so far.
    bit          m_active [2];
    bit          m_fin    [2];
    int unsigned m_ticks  [2];
    bit          m_pv, m_ps;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0] model_cnt(input int i);
        if (m_fin[i])               return 4'(ec[i]);
        if (!m_active[i])           return 4'd0;
        if (m_ticks[i] < sd[i])     return 4'd0;
        return 4'((m_ticks[i] - sd[i]) / fps[i]);
    endfunction

    task automatic model_step(input bit r, input bit s, input bit k, input bit v);
        bit   tk, tg, pulse;
        exp_t e [2];
        tk   = v && !m_pv;
        tg   = s && !m_ps;
        m_pv = r ? 1'b0 : v;
        m_ps = r ? 1'b0 : s;
        for (int i = 0; i < 2; i++) begin
            pulse = 1'b0;
            if (r) begin
                m_active[i] = 1'b0;
                m_fin[i]    = 1'b0;
                m_ticks[i]  = 0;
            end else if (m_active[i]) begin
                if (!s) begin
                    m_active[i] = 1'b0;
                end else if (k) begin
                    m_active[i] = 1'b0;
                    m_fin[i]    = 1'b1;
                    pulse       = 1'b1;
                end else if (tk) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == sd[i] + ec[i] * fps[i]) begin
                        m_active[i] = 1'b0;
                        m_fin[i]    = 1'b1;
                        pulse       = 1'b1;
                    end
                end
            end else if (m_fin[i]) begin
                if (!s) m_fin[i] = 1'b0;
            end else if (tg) begin
                m_active[i] = 1'b1;
                m_ticks[i]  = 0;
            end
            e[i].anim = m_active[i];
            e[i].cnt  = model_cnt(i);
            e[i].done = pulse;
        end
        q_a.push_back(e[0]);
        q_b.push_back(e[1]);
    endtask

    task automatic cyc(input bit r, input bit s, input bit k, input bit v);
        @(negedge clk);
        rst        = r;
        start_game = s;
        skip       = k;
        vblnk      = v;
        model_step(r, s, k, v);
    endtask

    task automatic frame(input bit s, input int hi, input int lo);
        repeat (hi) cyc(1'b0, s, 1'b0, 1'b1);
        repeat (lo) cyc(1'b0, s, 1'b0, 1'b0);
    endtask

    task automatic frames_until_cnt(input logic [3:0] target);
        for (int n = 0; n < 400 && model_cnt(0) != target; n++) frame(1'b1, 2, 2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                checks++;
                if ({anim_a, cnt_a, done_a} !== e) begin
                    errors++;
                    $display("FAIL dut_a outputs @%0t: got anim=%0b cnt=%0d done=%0b, expected anim=%0b cnt=%0d done=%0b",
                             $time, anim_a, cnt_a, done_a, e.anim, e.cnt, e.done);
                end
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                checks++;
                if ({anim_b, cnt_b, done_b} !== e) begin
                    errors++;
                    $display("FAIL dut_b outputs @%0t: got anim=%0b cnt=%0d done=%0b, expected anim=%0b cnt=%0d done=%0b",
                             $time, anim_b, cnt_b, done_b, e.anim, e.cnt, e.done);
                end
            end
        end
    end

    initial begin : stimulus
        bit s, k, v, r;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Nominal run: 150 frames then release
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (150) frame(1'b1, 2, 2);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Skip at step 5
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        frames_until_cnt(4'd5);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Abort at step 7
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        frames_until_cnt(4'd7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) frame(1'b0, 1, 1);

        // Abort, skip and tick together
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        frames_until_cnt(4'd3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // vblnk held high is a single tick
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (1000) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-delay, then restart only on a fresh edge
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) frame(1'b1, 2, 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) frame(1'b0, 2, 2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (40) frame(1'b1, 2, 2);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        s = 1'b0;
        v = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 99) == 0) s = ~s;
            if ($urandom_range(0, 2) == 0)  v = ~v;
            k = ($urandom_range(0, 79) == 0);
            r = ($urandom_range(0, 999) == 0);
            cyc(r, s, k, v);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expected entries left, required 0/0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
